// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction-fetch stage
package fetch_pkg;

   typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} fetch_state_t;

   localparam int DEF_PC_W    = 10;
   localparam int DEF_INSTR_W = 9;
   localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/instr_fetch_sat_counter.sv
// rtl/instr_fetch_sat_counter.sv - saturating up-counter with synchronous clear
// clr together with en loads 1 so the clearing cycle itself is still counted.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= en ? W'(1) : '0;
      end else if (en && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, ROM fetch, mode register and run counters
// Address is combinational so the synchronous ROM returns the next instruction with zero bubbles.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int              PC_W     = DEF_PC_W,
   parameter int              INSTR_W  = DEF_INSTR_W,
   parameter int              CNT_W    = DEF_CNT_W,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   input  logic               halt_req,
   input  logic               mode_next,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   output logic               modeQ,
   output logic [PC_W-1:0]    pc_out,
   output logic               done,
   output logic [CNT_W-1:0]   retired_cnt,
   output logic [CNT_W-1:0]   cycle_cnt
);

   fetch_state_t    r_state, w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic            r_mode;
   logic [PC_W-1:0] w_addr;
   logic            w_consume, w_halt, w_branch, w_fill, w_run;

   assign w_fill    = (r_state == FILL);
   assign w_run     = (r_state == RUN);
   assign w_consume = w_run & ~stall;
   // halt has priority: a halting instruction never redirects or updates mode
   assign w_halt    = w_consume & halt_req;
   assign w_branch  = w_consume & branch_taken & ~halt_req;

   always_comb begin
      w_state_nxt = r_state;
      w_addr      = r_pc;
      case (r_state)
         IDLE: begin
            w_addr = START_PC;
            if (start) w_state_nxt = FILL;
         end
         FILL: begin
            w_addr      = START_PC;
            w_state_nxt = RUN;
         end
         RUN: begin
            if (w_halt)           w_state_nxt = DONE;
            else if (w_branch)    w_addr = branch_target;
            else if (w_consume)   w_addr = r_pc + PC_W'(1);
         end
         DONE: begin
            if (start) w_state_nxt = FILL;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pc    <= '0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fill) begin
            r_pc   <= START_PC;
            r_mode <= 1'b0;
         end else if (w_run) begin
            r_pc <= w_addr;
            if (w_consume && !halt_req) r_mode <= mode_next;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_retired (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_consume),
      .clr   (w_fill),
      .q     (retired_cnt)
   );

   sat_counter #(.W(CNT_W)) u_cycle (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_fill | w_run),
      .clr   (w_fill),
      .q     (cycle_cnt)
   );

   assign imem_addr   = w_addr;
   assign instr_out   = imem_rdata;
   assign instr_valid = w_run;
   assign modeQ       = r_mode;
   assign pc_out      = r_pc;
   assign done        = (r_state == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a behavioural model
module tb_instr_fetch;

   localparam int PC_W    = 10;
   localparam int INSTR_W = 9;
   localparam int CNT_W   = 8;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk, rst_n, start, stall, branch_taken, halt_req, mode_next;
   logic [PC_W-1:0]    branch_target, imem_addr, pc_out;
   logic [INSTR_W-1:0] imem_rdata, instr_out;
   logic               instr_valid, modeQ, done;
   logic [CNT_W-1:0]   retired_cnt, cycle_cnt;

   logic [INSTR_W-1:0] rom [PC_MOD];

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   instr_fetch #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W), .START_PC(10'd0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .halt_req(halt_req), .mode_next(mode_next), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .instr_out(instr_out), .instr_valid(instr_valid),
      .modeQ(modeQ), .pc_out(pc_out), .done(done),
      .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= rom[imem_addr];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int sat_inc(input int x);
      return (x >= CNT_MAX) ? CNT_MAX : x + 1;
   endfunction

   // model phase: 0 idle, 1 filling, 2 running, 3 finished
   int m_ph, m_pc, m_ret, m_cyc;
   bit m_mode;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = 0; m_pc = 0; m_mode = 0; m_ret = 0; m_cyc = 0;
      end else begin
         case (m_ph)
            0: if (start) m_ph = 1;
            1: begin m_ph = 2; m_pc = 0; m_mode = 0; m_ret = 0; m_cyc = 1; end
            2: begin
               m_cyc = sat_inc(m_cyc);
               if (!stall) begin
                  m_ret = sat_inc(m_ret);
                  if (halt_req) m_ph = 3;
                  else begin
                     m_mode = mode_next;
                     m_pc   = branch_taken ? int'(branch_target) : (m_pc + 1) % PC_MOD;
                  end
               end
            end
            default: if (start) m_ph = 1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_valid",   int'(instr_valid), int'(m_ph == 2));
         chk("m_done",    int'(done),        int'(m_ph == 3));
         chk("m_pc",      int'(pc_out),      m_pc);
         chk("m_mode",    int'(modeQ),       int'(m_mode));
         chk("m_retired", int'(retired_cnt), m_ret);
         chk("m_cycles",  int'(cycle_cnt),   m_cyc);
         if (m_ph == 2) chk("m_instr", int'(instr_out), int'(rom[m_pc]));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < PC_MOD; i++) rom[i] = (i < 512) ? INSTR_W'(i) : INSTR_W'($urandom);
      rst_n = 0; start = 0; stall = 0; branch_taken = 0; branch_target = '0;
      halt_req = 0; mode_next = 0;
      repeat (2) step();
      chk_en = 1;
      chk("rst_valid", int'(instr_valid), 0);
      chk("rst_done",  int'(done), 0);
      chk("rst_ret",   int'(retired_cnt), 0);
      chk("rst_cyc",   int'(cycle_cnt), 0);
      chk("rst_mode",  int'(modeQ), 0);
      rst_n = 1;
      step();

      // start, one fill cycle, sequential fetch
      start = 1; step(); start = 0;
      chk("fill_valid", int'(instr_valid), 0);
      step();
      chk("run_pc0", int'(pc_out), 0);
      chk("run_valid", int'(instr_valid), 1);
      chk("run_instr0", int'(instr_out), 0);
      step(); chk("run_pc1", int'(pc_out), 1);
      step(); chk("run_pc2", int'(pc_out), 2);
      mode_next = 1; step();
      chk("mode_pc3", int'(pc_out), 3);
      chk("mode_set", int'(modeQ), 1);
      mode_next = 0; step();
      chk("mode_clr", int'(modeQ), 0);
      chk("instr4", int'(instr_out), 4);

      // stalled branch ignored, then zero-bubble redirect
      stall = 1; branch_taken = 1; branch_target = 10'h200; step();
      chk("stall_branch_pc", int'(pc_out), 4);
      stall = 0; step();
      chk("branch_pc", int'(pc_out), 'h200);
      chk("branch_valid", int'(instr_valid), 1);
      branch_target = 10'd5; step(); branch_taken = 0;
      chk("branch_pc5", int'(pc_out), 5);

      // three stall cycles hold pc, instruction and mode
      stall = 1; mode_next = 1;
      repeat (3) begin
         step();
         chk("stall_pc", int'(pc_out), 5);
         chk("stall_instr", int'(instr_out), 5);
         chk("stall_mode", int'(modeQ), 0);
      end
      stall = 0; mode_next = 0; step();
      chk("release_pc", int'(pc_out), 6);

      // ten retirements, start in RUN ignored, halt beats branch
      rst_n = 0; step(); rst_n = 1;
      start = 1; step(); start = 0; step();
      for (int i = 0; i < 9; i++) begin
         start = (i == 3); step();
      end
      start = 0;
      chk("pre_halt_pc", int'(pc_out), 9);
      chk("pre_halt_ret", int'(retired_cnt), 9);
      halt_req = 1; branch_taken = 1; branch_target = 10'd3; step();
      halt_req = 0; branch_taken = 0;
      chk("halt_done", int'(done), 1);
      chk("halt_pc", int'(pc_out), 9);
      chk("halt_ret", int'(retired_cnt), 10);
      chk("halt_valid", int'(instr_valid), 0);
      chk("halt_cyc", int'(cycle_cnt), 11);
      stall = 1; step(); stall = 0;
      chk("done_frozen_ret", int'(retired_cnt), 10);

      // restart from DONE, wrap at top of address space, async reset mid-RUN
      start = 1; step(); start = 0; step();
      chk("restart_ret", int'(retired_cnt), 0);
      chk("restart_cyc", int'(cycle_cnt), 1);
      branch_taken = 1; branch_target = 10'h3FF; mode_next = 1; step(); branch_taken = 0;
      chk("top_pc", int'(pc_out), 'h3FF);
      step();
      chk("wrap_pc", int'(pc_out), 0);
      chk("wrap_mode", int'(modeQ), 1);
      mode_next = 0;
      @(posedge clk); #3;
      rst_n = 0; #1;
      chk("arst_valid", int'(instr_valid), 0);
      chk("arst_mode", int'(modeQ), 0);
      chk("arst_ret", int'(retired_cnt), 0);
      chk("arst_cyc", int'(cycle_cnt), 0);
      step(); rst_n = 1;

      // randomized traffic against the model
      for (int n = 0; n < 5000; n++) begin
         start         = ($urandom_range(0, 19) == 0);
         stall         = ($urandom_range(0, 3) == 0);
         branch_taken  = ($urandom_range(0, 7) == 0);
         branch_target = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1022, 1023)) : 10'($urandom);
         halt_req      = ($urandom_range(0, 299) == 0);
         mode_next     = 1'($urandom);
         if ($urandom_range(0, 999) == 0) rst_n = 0;
         step();
         rst_n = 1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
